// File: rtl/accum_pkg.sv
// Shared types and sizing helpers for the switch-driven accumulator.
package accum_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'b00,
    ADD  = 2'b01,
    SUB  = 2'b10,
    UNDO = 2'b11
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Width needed to count 0..depth history entries.
  function automatic int unsigned hist_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hist_stack.sv
// Bounded circular LIFO of previous accumulator values; push-on-full drops the oldest.
module hist_stack
  import accum_pkg::*;
#(
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned HIST_DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  logic                                pop,
  input  logic [ACC_W-1:0]                    din,
  output logic [ACC_W-1:0]                    top,
  output logic [hist_cnt_w(HIST_DEPTH)-1:0]   count
);

  localparam int unsigned CNT_W = hist_cnt_w(HIST_DEPTH);
  localparam int unsigned PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  logic [ACC_W-1:0] mem [HIST_DEPTH];
  logic [PTR_W-1:0] head;      // next slot to write
  logic [PTR_W-1:0] head_inc;
  logic [PTR_W-1:0] head_dec;  // slot holding the most recent entry

  // Wrap the head pointer at HIST_DEPTH in both directions.
  always_comb begin
    head_inc = (head == PTR_W'(HIST_DEPTH - 1)) ? '0 : head + PTR_W'(1);
    head_dec = (head == '0) ? PTR_W'(HIST_DEPTH - 1) : head - PTR_W'(1);
  end

  assign top = mem[head_dec];

  // Entry storage; contents need no reset since count gates validity.
  always_ff @(posedge clk) begin
    if (push) mem[head] <= din;
  end

  // Head pointer and occupancy; a full push overwrites the oldest slot in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      count <= '0;
    end else if (push) begin
      head <= head_inc;
      if (count != CNT_W'(HIST_DEPTH)) count <= count + CNT_W'(1);
    end else if (pop) begin
      head  <= head_dec;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/accum_stack.sv
// Switch-driven accumulator: one load/add/sub/undo per Run press, wrap or saturate.
module accum_stack
  import accum_pkg::*;
#(
  parameter int unsigned IN_W       = 10,
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned HIST_DEPTH = 4
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Run,
  input  logic [1:0]                        Op,
  input  logic                              Sat,
  input  logic [IN_W-1:0]                   Din,
  output logic [ACC_W-1:0]                  Acc,
  output logic                              Flag,
  output logic                              Done,
  output logic                              Err,
  output logic [hist_cnt_w(HIST_DEPTH)-1:0] Hist_cnt
);

  state_t           state, state_nxt;
  op_t              op;
  logic [ACC_W-1:0] din_ext;
  logic [ACC_W:0]   sum, diff;
  logic [ACC_W-1:0] acc_nxt, hist_top;
  logic             flag_nxt, done_nxt, err_nxt;
  logic             push, pop;

  assign op      = op_t'(Op);
  assign din_ext = ACC_W'(Din);
  assign sum     = {1'b0, Acc} + {1'b0, din_ext};
  assign diff    = {1'b0, Acc} - {1'b0, din_ext};

  hist_stack #(
    .ACC_W      (ACC_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk   (Clk),
    .reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (Acc),
    .top   (hist_top),
    .count (Hist_cnt)
  );

  // Next-state and datapath select; an operation fires only on Run seen in IDLE.
  always_comb begin
    state_nxt = state;
    acc_nxt   = Acc;
    flag_nxt  = Flag;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (Run) begin
          state_nxt = HOLD;
          case (op)
            LOAD: begin
              acc_nxt  = din_ext;
              flag_nxt = 1'b0;
              push     = 1'b1;
              done_nxt = 1'b1;
            end
            ADD: begin
              if (sum[ACC_W]) flag_nxt = 1'b1;
              acc_nxt  = (sum[ACC_W] && Sat) ? '1 : sum[ACC_W-1:0];
              push     = 1'b1;
              done_nxt = 1'b1;
            end
            SUB: begin
              if (diff[ACC_W]) flag_nxt = 1'b1;
              acc_nxt  = (diff[ACC_W] && Sat) ? '0 : diff[ACC_W-1:0];
              push     = 1'b1;
              done_nxt = 1'b1;
            end
            UNDO: begin
              if (Hist_cnt != '0) begin
                acc_nxt  = hist_top;
                pop      = 1'b1;
                done_nxt = 1'b1;
              end else begin
                err_nxt = 1'b1;
              end
            end
          endcase
        end
      end
      HOLD: begin
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator, sticky flag and pulse registers; Reset wins over any trigger.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Acc   <= '0;
      Flag  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      state <= state_nxt;
      Acc   <= acc_nxt;
      Flag  <= flag_nxt;
      Done  <= done_nxt;
      Err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_accum_stack.sv
// Directed self-checking bench for accum_stack at default parameters.
module tb_accum_stack;

  localparam int unsigned IN_W       = 10;
  localparam int unsigned ACC_W      = 16;
  localparam int unsigned HIST_DEPTH = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Run;
  logic [1:0]        Op;
  logic              Sat;
  logic [IN_W-1:0]   Din;
  logic [ACC_W-1:0]  Acc;
  logic              Flag, Done, Err;
  logic [2:0]        Hist_cnt;

  int checks = 0;
  int errors = 0;
  int done_cnt, err_cnt;

  accum_stack #(.IN_W(IN_W), .ACC_W(ACC_W), .HIST_DEPTH(HIST_DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Op(Op), .Sat(Sat), .Din(Din),
    .Acc(Acc), .Flag(Flag), .Done(Done), .Err(Err), .Hist_cnt(Hist_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One press: Run high for n cycles (inputs scrambled after the trigger), then one low cycle.
  task automatic press(input logic [1:0] o, input logic s, input logic [IN_W-1:0] d, input int n);
    done_cnt = 0;
    err_cnt  = 0;
    @(negedge Clk);
    Run = 1'b1; Op = o; Sat = s; Din = d;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
      if (Err) err_cnt++;
      Op  = 2'($urandom);
      Sat = 1'($urandom);
      Din = IN_W'($urandom);
    end
    Run = 1'b0;
    @(negedge Clk);
    if (Done) done_cnt++;
    if (Err) err_cnt++;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Op = 2'b00; Sat = 1'b0; Din = '0;
    repeat (2) @(negedge Clk);
    chk("rst_acc", 32'(Acc), 32'h0);
    chk("rst_flag", 32'(Flag), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_err", 32'(Err), 32'h0);
    chk("rst_hist", 32'(Hist_cnt), 32'h0);
    Reset = 1'b0;

    press(2'b00, 1'b0, 10'h3FF, 1);
    chk("load_acc", 32'(Acc), 32'h03FF);
    chk("load_flag", 32'(Flag), 32'h0);
    chk("load_hist", 32'(Hist_cnt), 32'h1);
    chk("load_done", 32'(done_cnt), 32'h1);

    press(2'b01, 1'b0, 10'h001, 20);
    chk("hold_acc", 32'(Acc), 32'h0400);
    chk("hold_hist", 32'(Hist_cnt), 32'h2);
    chk("hold_done", 32'(done_cnt), 32'h1);

    press(2'b00, 1'b0, 10'h000, 1);
    press(2'b10, 1'b0, 10'h010, 1);
    chk("mk_fff0", 32'(Acc), 32'hFFF0);
    press(2'b01, 1'b0, 10'h020, 1);
    chk("add_wrap_acc", 32'(Acc), 32'h0010);
    chk("add_wrap_flag", 32'(Flag), 32'h1);

    press(2'b00, 1'b0, 10'h000, 1);
    chk("load_clr_flag", 32'(Flag), 32'h0);
    press(2'b10, 1'b0, 10'h010, 1);
    press(2'b01, 1'b1, 10'h020, 1);
    chk("add_sat_acc", 32'(Acc), 32'hFFFF);
    chk("add_sat_flag", 32'(Flag), 32'h1);

    press(2'b00, 1'b0, 10'h005, 1);
    chk("load5_flag", 32'(Flag), 32'h0);
    chk("hist_full", 32'(Hist_cnt), 32'h4);
    press(2'b10, 1'b0, 10'h009, 1);
    chk("sub_wrap_acc", 32'(Acc), 32'hFFFC);
    chk("sub_wrap_flag", 32'(Flag), 32'h1);
    press(2'b00, 1'b0, 10'h005, 1);
    press(2'b10, 1'b1, 10'h009, 1);
    chk("sub_sat_acc", 32'(Acc), 32'h0000);
    chk("sub_sat_flag", 32'(Flag), 32'h1);

    press(2'b00, 1'b0, 10'h001, 1);
    for (int i = 0; i < 5; i++) press(2'b01, 1'b0, 10'h001, 1);
    chk("pre_undo_acc", 32'(Acc), 32'h6);
    chk("pre_undo_hist", 32'(Hist_cnt), 32'h4);
    for (int i = 0; i < 4; i++) begin
      press(2'b11, 1'b0, 10'h000, 1);
      chk("undo_acc", 32'(Acc), 32'(5 - i));
      chk("undo_hist", 32'(Hist_cnt), 32'(3 - i));
      chk("undo_done", 32'(done_cnt), 32'h1);
    end
    press(2'b11, 1'b0, 10'h000, 1);
    chk("undo5_err", 32'(err_cnt), 32'h1);
    chk("undo5_done", 32'(done_cnt), 32'h0);
    chk("undo5_acc", 32'(Acc), 32'h2);
    chk("undo5_hist", 32'(Hist_cnt), 32'h0);
    press(2'b11, 1'b0, 10'h000, 1);
    chk("undo6_err", 32'(err_cnt), 32'h1);
    chk("undo6_acc", 32'(Acc), 32'h2);

    // Reset coinciding with an ADD trigger, Run held through release.
    @(negedge Clk);
    Run = 1'b1; Op = 2'b01; Sat = 1'b0; Din = 10'h001; Reset = 1'b1;
    @(negedge Clk);
    chk("rst_trig_acc", 32'(Acc), 32'h0);
    chk("rst_trig_done", 32'(Done), 32'h0);
    chk("rst_trig_hist", 32'(Hist_cnt), 32'h0);
    Reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (Done) done_cnt++;
    end
    Run = 1'b0;
    @(negedge Clk);
    chk("post_rst_acc", 32'(Acc), 32'h1);
    chk("post_rst_done", 32'(done_cnt), 32'h1);
    chk("post_rst_hist", 32'(Hist_cnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accum_stack.md
# accum_stack

Parametrised switch-driven accumulator, the successor to the 17-bit lab accumulator. Sits between the board switch/button front end and the hex display drivers. Generalised data width, load/add/subtract/undo operation modes, wrap or saturate arithmetic, sticky carry/borrow and a bounded undo history. Executes one operation per Run press.

## Interface
Parameters:
- IN_W, default 10: switch operand width.
- ACC_W, default 16: accumulator width. Must satisfy ACC_W ≥ IN_W.
- HIST_DEPTH, default 4: undo history entries. Must be ≥ 1.

Ports:
- Clk, in, 1: single clock.
- Reset, in, 1: synchronous, active-high reset. Inversion of the board button is done outside this block.
- Run, in, 1: active-high level, already synchronised; one operation per high period.
- Op, in, 2: 00 LOAD, 01 ADD, 10 SUB, 11 UNDO. Sampled with Run.
- Sat, in, 1: 1 = saturate, 0 = wrap. Sampled with Run.
- Din, in, IN_W: operand, zero-extended to ACC_W.
- Acc, out, ACC_W: accumulator value.
- Flag, out, 1: sticky carry (ADD) / borrow (SUB).
- Done, out, 1: one-cycle pulse after an operation commits.
- Err, out, 1: one-cycle pulse when UNDO is issued with an empty history.
- Hist_cnt, out, $clog2(HIST_DEPTH+1): number of valid history entries.

## Operation
- FSM states:
  - IDLE: on Run=1, execute Op and go to HOLD.
  - HOLD: wait for Run=0, then return to IDLE.
  - A Run held high for N cycles executes exactly one operation.
- LOAD: Acc ← zext(Din); Flag ← 0; push old Acc.
- ADD: compute Acc + zext(Din) at ACC_W+1 bits; push old Acc.
  - Carry out (bit ACC_W) = 1 → Flag ← 1.
  - Sat=1 → Acc ← all-ones; Sat=0 → Acc ← low ACC_W bits.
- SUB: compute Acc − zext(Din); push old Acc.
  - Borrow → Flag ← 1.
  - Sat=1 → Acc ← 0; Sat=0 → Acc ← two's-complement wrap.
- UNDO:
  - Hist_cnt > 0: Acc ← top entry; pop; Flag unchanged.
  - Hist_cnt = 0: Acc unchanged, Err pulses, Done does not pulse.
- Flag is sticky. It is cleared only by LOAD or Reset.
- History is a circular LIFO. Pushing when full overwrites the oldest entry; Hist_cnt stays at HIST_DEPTH.
- Reset values: Acc=0, Flag=0, Done=0, Err=0, Hist_cnt=0, FSM=IDLE. History contents are don't-care.

## Timing
- Run sampled 1 in IDLE at edge k:
  - Acc, Flag and Hist_cnt take their new values after edge k.
  - Done (or Err) is high for the cycle after edge k only.
- Earliest re-trigger: Run=0 sampled at edge k+1, Run=1 at edge k+2. Maximum rate is one operation per 2 cycles.
- Op, Sat and Din are ignored except at the triggering edge. Changes during HOLD have no effect.
- Reset has priority over everything. Reset asserted in the same cycle as a trigger: no operation, no Done, FSM=IDLE.
- Reset asserted during HOLD: FSM=IDLE. If Run is still high after Reset releases, it is treated as a new press and executes.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package accum_pkg:
  - op_t enum: LOAD, ADD, SUB, UNDO.
  - state_t enum: IDLE, HOLD.
  - HIST_CNT_W helper function.
- Sub-module hist_stack #(ACC_W, HIST_DEPTH):
  - Ports: push, pop, din, top, count.
  - Circular buffer with wrapping head pointer; push-on-full drops the oldest entry.
  - push and pop are never asserted together.
- Top level: FSM, ACC_W+1-bit add/sub datapath, saturation mux, Flag register, pulse registers.

## Test plan
- Reset; LOAD Din=0x3FF → Acc=0x03FF, Flag=0, Hist_cnt=1, Done pulses once.
- Hold Run high for 20 cycles with ADD Din=1 → exactly one add: Acc=0x0400, Hist_cnt=2.
- Acc=0xFFF0, ADD Din=0x20:
  - Sat=0 → Acc=0x0010, Flag=1.
  - Repeat from 0xFFF0 with Sat=1 → Acc=0xFFFF, Flag=1.
  - Following LOAD clears Flag.
- Acc=0x0005, SUB Din=0x9:
  - Sat=0 → Acc=0xFFFC, Flag=1.
  - Sat=1 → Acc=0x0000, Flag=1.
- HIST_DEPTH=4: LOAD 1, then ADD 1 five times (Acc=6); six UNDOs:
  - Acc goes 5, 4, 3, 2.
  - 5th UNDO: Err pulses, Acc=2, Hist_cnt=0.
  - 6th UNDO: Err pulses again.
- Reset in the trigger cycle of an ADD → Acc=0, no Done. Run still high after release → ADD executes once.
